// File: rtl/fim_ram_1r1w_ctrl.sv
// rtl/fim_ram_1r1w_ctrl.sv - init, round-robin read arbitration and return routing for fim_ram_1r1w
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   init_done                 high once every RAM entry holds INIT_VALUE
//   wr_valid/wr_ready         write request / accept (accept equals init_done)
//   wr_addr, wr_data          write address and data
//   rd_req[1:0]               per-requester read request, held until granted
//   rd_addr0, rd_addr1        per-requester read address
//   rd_gnt[1:0]               combinational one-hot read grant
//   rd_valid[1:0]             one-hot read return strobe, RD_LATENCY after grant
//   rd_data, rd_perr          returned data and its parity error
//   perr_sticky, perr_addr    latched first parity error and its address
//   perr_clr                  clears the latched parity error
//   ram_*                     connections to the fim_ram_1r1w instance
module fim_ram_1r1w_ctrl #(
   parameter int DEPTH      = 4,
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 2,
   parameter int WR_TO_RD   = 2,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             init_done,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [1:0]       rd_req,
   input  logic [DEPTH-1:0] rd_addr0,
   input  logic [DEPTH-1:0] rd_addr1,
   output logic [1:0]       rd_gnt,
   output logic [1:0]       rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_perr,
   output logic             perr_sticky,
   output logic [DEPTH-1:0] perr_addr,
   input  logic             perr_clr,
   output logic             ram_we,
   output logic [DEPTH-1:0] ram_waddr,
   output logic [WIDTH-1:0] ram_din,
   output logic [DEPTH-1:0] ram_raddr,
   output logic             ram_re,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic             ram_perr
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state;
   logic [DEPTH-1:0] init_cnt;
   logic             prev_we;
   logic [DEPTH-1:0] prev_waddr;
   logic             last_gnt;     // index of the requester granted most recently

   // Return pipeline: stage 0 is loaded on grant, the last stage lines up with ram_dout.
   logic [RD_LATENCY-1:0] pipe_v;
   logic [RD_LATENCY-1:0] pipe_idx;
   logic [DEPTH-1:0]      pipe_addr [RD_LATENCY];

   logic run;
   logic hit0, hit1;
   logic elig0, elig1;
   logic ret_v;

   assign run   = (state == S_RUN);
   assign ret_v = pipe_v[RD_LATENCY-1];

   // A read must not see a location whose write has not yet become visible.
   assign hit0 = (wr_valid && (wr_addr == rd_addr0)) ||
                 ((WR_TO_RD >= 2) && prev_we && (prev_waddr == rd_addr0));
   assign hit1 = (wr_valid && (wr_addr == rd_addr1)) ||
                 ((WR_TO_RD >= 2) && prev_we && (prev_waddr == rd_addr1));

   assign elig0 = run && rd_req[0] && !hit0;
   assign elig1 = run && rd_req[1] && !hit1;

   always_comb begin
      rd_gnt = 2'b00;
      if (elig0 && elig1)
         rd_gnt = last_gnt ? 2'b01 : 2'b10;
      else
         rd_gnt = {elig1, elig0};
   end

   assign ram_re    = |rd_gnt;
   assign ram_raddr = rd_gnt[1] ? rd_addr1 : rd_addr0;

   // Init writes are gated by rst so the RAM sees no write while reset is held.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = init_cnt;
      ram_din   = INIT_VALUE;
      if (run) begin
         ram_we    = wr_valid;
         ram_waddr = wr_addr;
         ram_din   = wr_data;
      end else begin
         ram_we    = !rst;
      end
   end

   assign wr_ready = init_done;
   assign rd_valid = ret_v ? (pipe_idx[RD_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
   assign rd_data  = ram_dout;
   assign rd_perr  = ram_perr & ret_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_INIT;
         init_cnt    <= '0;
         init_done   <= 1'b0;
         prev_we     <= 1'b0;
         prev_waddr  <= '0;
         last_gnt    <= 1'b1;
         pipe_v      <= '0;
         pipe_idx    <= '0;
         for (int i = 0; i < RD_LATENCY; i++)
            pipe_addr[i] <= '0;
         perr_sticky <= 1'b0;
         perr_addr   <= '0;
      end else begin
         case (state)
            S_INIT: begin
               init_cnt <= init_cnt + DEPTH'(1);
               if (init_cnt == '1) begin
                  state     <= S_RUN;
                  init_done <= 1'b1;
               end
            end
            default: ;
         endcase

         prev_we    <= ram_we;
         prev_waddr <= ram_waddr;

         if (ram_re)
            last_gnt <= rd_gnt[1];

         pipe_v[0]    <= ram_re;
         pipe_idx[0]  <= rd_gnt[1];
         pipe_addr[0] <= ram_raddr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_idx[i]  <= pipe_idx[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end

         if (perr_clr) begin
            perr_sticky <= 1'b0;
            perr_addr   <= '0;
         end else if (rd_perr && !perr_sticky) begin
            perr_sticky <= 1'b1;
            perr_addr   <= pipe_addr[RD_LATENCY-1];
         end
      end
   end

endmodule

// File: tb/tb_fim_ram_1r1w_ctrl.sv
// tb/tb_fim_ram_1r1w_ctrl.sv - self-checking bench for fim_ram_1r1w_ctrl
module tb_fim_ram_1r1w_ctrl;

   localparam int DEPTH   = 4;
   localparam int WIDTH   = 32;
   localparam int RD_LAT  = 2;
   localparam int W2R     = 2;
   localparam int ENTRIES = 1 << DEPTH;
   localparam logic [WIDTH-1:0] INIT_V = '0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             init_done, wr_ready;
   logic             wr_valid = 1'b0;
   logic [DEPTH-1:0] wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [1:0]       rd_req = 2'b00;
   logic [DEPTH-1:0] rd_addr0 = '0, rd_addr1 = '0;
   logic [1:0]       rd_gnt, rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_perr, perr_sticky;
   logic [DEPTH-1:0] perr_addr;
   logic             perr_clr = 1'b0;
   logic             ram_we, ram_re;
   logic [DEPTH-1:0] ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_din;
   logic [WIDTH-1:0] ram_dout;
   logic             ram_perr;

   always #5 clk = ~clk;

   fim_ram_1r1w_ctrl #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LATENCY(RD_LAT), .WR_TO_RD(W2R), .INIT_VALUE(INIT_V)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr),
      .perr_sticky(perr_sticky), .perr_addr(perr_addr), .perr_clr(perr_clr),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
      .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout), .ram_perr(ram_perr)
   );

   // Behavioural RAM: two-cycle read latency, parity error injected per address.
   logic [WIDTH-1:0] ram_mem [ENTRIES];
   logic             m_mask  [ENTRIES];
   logic [WIDTH-1:0] d1 = '0, d2 = '0;
   logic             pe1 = 1'b0, pe2 = 1'b0;

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_waddr] <= ram_din;
      if (ram_re) begin
         d1  <= ram_mem[ram_raddr];
         pe1 <= m_mask[ram_raddr];
      end else begin
         pe1 <= 1'b0;
      end
      d2  <= d1;
      pe2 <= pe1;
   end
   assign ram_dout = d2;
   assign ram_perr = pe2;

   // Reference model state
   typedef struct {
      int               due;
      logic             idx;
      logic [WIDTH-1:0] data;
      logic             perr;
      logic [DEPTH-1:0] addr;
   } ret_t;

   ret_t             q[$];
   logic [WIDTH-1:0] m_mem [ENTRIES];
   logic             m_last;
   logic             m_pwe;
   logic [DEPTH-1:0] m_pwa;
   logic             m_sticky;
   logic [DEPTH-1:0] m_paddr;
   int               cyc = 0;
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic hazard(input logic [DEPTH-1:0] a);
      return (wr_valid && wr_addr == a) || (W2R == 2 && m_pwe && m_pwa == a);
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < ENTRIES; i++) m_mem[i] = INIT_V;
      m_last   = 1'b1;
      m_pwe    = 1'b1;
      m_pwa    = DEPTH'(ENTRIES - 1);
      m_sticky = 1'b0;
      m_paddr  = '0;
   endtask

   // Checks the INIT sweep; rst must already be low and we are #1 after a posedge.
   task automatic init_seq();
      for (int k = 0; k < ENTRIES; k++) begin
         @(negedge clk);
         chk("init_we", ram_we, 1'b1);
         chk("init_waddr", ram_waddr, k);
         chk("init_din", ram_din, INIT_V);
         chk("init_gnt", rd_gnt, 2'b00);
         chk("init_re", ram_re, 1'b0);
         chk("init_done_lo", init_done, 1'b0);
         chk("init_wr_ready_lo", wr_ready, 1'b0);
         @(posedge clk); #1;
      end
      chk("init_done_hi", init_done, 1'b1);
      chk("wr_ready_hi", wr_ready, 1'b1);
      model_reset();
   endtask

   // One RUN cycle: check outputs against the model, then advance the model over the edge.
   task automatic step();
      logic [1:0]       g;
      logic             e0, e1, ret_now;
      logic [DEPTH-1:0] a;
      ret_t             r;
      @(negedge clk);
      e0 = rd_req[0] && !hazard(rd_addr0);
      e1 = rd_req[1] && !hazard(rd_addr1);
      if (e0 && e1) g = m_last ? 2'b01 : 2'b10;
      else          g = {e1, e0};
      chk("rd_gnt", rd_gnt, g);
      chk("ram_re", ram_re, |g);
      if (|g) chk("ram_raddr", ram_raddr, g[1] ? rd_addr1 : rd_addr0);
      chk("ram_we", ram_we, wr_valid);
      if (wr_valid) begin
         chk("ram_waddr", ram_waddr, wr_addr);
         chk("ram_din", ram_din, wr_data);
      end
      ret_now = (q.size() > 0) && (q[0].due == cyc);
      if (ret_now) begin
         r = q.pop_front();
         chk("rd_valid", rd_valid, r.idx ? 2'b10 : 2'b01);
         chk("rd_data", rd_data, r.data);
         chk("rd_perr", rd_perr, r.perr);
      end else begin
         chk("rd_valid_idle", rd_valid, 2'b00);
         chk("rd_perr_idle", rd_perr, 1'b0);
      end
      chk("perr_sticky", perr_sticky, m_sticky);
      chk("perr_addr", perr_addr, m_paddr);

      if (perr_clr) begin
         m_sticky = 1'b0;
         m_paddr  = '0;
      end else if (ret_now && r.perr && !m_sticky) begin
         m_sticky = 1'b1;
         m_paddr  = r.addr;
      end
      if (|g) begin
         a = g[1] ? rd_addr1 : rd_addr0;
         q.push_back('{due: cyc + RD_LAT, idx: g[1], data: m_mem[a], perr: m_mask[a], addr: a});
         m_last = g[1];
      end
      if (wr_valid) m_mem[wr_addr] = wr_data;
      m_pwe = wr_valid;
      m_pwa = wr_addr;

      @(posedge clk); #1;
      cyc++;
      if (g[0]) rd_req[0] = 1'b0;
      if (g[1]) rd_req[1] = 1'b0;
      wr_valid = 1'b0;
      perr_clr = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < ENTRIES; i++) begin
         m_mask[i]  = 1'b0;
         ram_mem[i] = '0;
      end
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_rd_gnt", rd_gnt, 2'b00);
      chk("rst_rd_valid", rd_valid, 2'b00);
      chk("rst_rd_perr", rd_perr, 1'b0);
      chk("rst_perr_sticky", perr_sticky, 1'b0);
      chk("rst_perr_addr", perr_addr, '0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_re", ram_re, 1'b0);

      // Requests held through INIT must wait for init_done.
      rd_req   = 2'b11;
      rd_addr0 = 4'd2;
      rd_addr1 = 4'd3;
      rst      = 1'b0;
      init_seq();
      repeat (4) step();

      // Fill RAM with random data.
      for (int a = 0; a < ENTRIES; a++) begin
         wr_valid = 1'b1;
         wr_addr  = DEPTH'(a);
         wr_data  = $urandom;
         step();
      end

      // Round robin: both requesters held, distinct addresses.
      for (int k = 0; k < 4; k++) begin
         if (!rd_req[0]) begin rd_req[0] = 1'b1; rd_addr0 = DEPTH'(k); end
         if (!rd_req[1]) begin rd_req[1] = 1'b1; rd_addr1 = DEPTH'(k + 8); end
         step();
      end
      rd_req = 2'b00;
      repeat (3) step();

      // Previous-cycle write hazard on requester 0 only.
      wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5A5_0005;
      step();
      rd_req = 2'b11; rd_addr0 = 4'd5; rd_addr1 = 4'd6;
      repeat (5) step();

      // Same-cycle write hazard.
      wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h7777_0007;
      rd_req[0] = 1'b1; rd_addr0 = 4'd7;
      repeat (5) step();

      // Parity errors: first on 9, then on 3; only the first is latched.
      m_mask[9] = 1'b1;
      m_mask[3] = 1'b1;
      rd_req[0] = 1'b1; rd_addr0 = 4'd9;
      step();
      rd_req[0] = 1'b1; rd_addr0 = 4'd3;
      step();
      repeat (3) step();
      chk("perr_sticky_set", perr_sticky, 1'b1);
      chk("perr_addr_first", perr_addr, 4'd9);
      perr_clr = 1'b1;
      step();
      chk("perr_sticky_clr", perr_sticky, 1'b0);
      chk("perr_addr_clr", perr_addr, '0);
      m_mask[9] = 1'b0;
      m_mask[3] = 1'b0;

      // Randomised traffic.
      m_mask[12] = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!rd_req[0] && $urandom_range(0, 1) == 1) begin
            rd_req[0] = 1'b1; rd_addr0 = DEPTH'($urandom_range(0, ENTRIES - 1));
         end
         if (!rd_req[1] && $urandom_range(0, 1) == 1) begin
            rd_req[1] = 1'b1; rd_addr1 = DEPTH'($urandom_range(0, ENTRIES - 1));
         end
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr  = DEPTH'($urandom_range(0, ENTRIES - 1));
         wr_data  = $urandom;
         perr_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      rd_req = 2'b00;
      repeat (4) step();
      m_mask[12] = 1'b0;

      // Reset with reads in flight: returns dropped, INIT restarts at 0.
      rd_req = 2'b11; rd_addr0 = 4'd1; rd_addr1 = 4'd4;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rstmid_rd_valid", rd_valid, 2'b00);
      chk("rstmid_ram_we", ram_we, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstmid_rd_valid_hold", rd_valid, 2'b00);
         chk("rstmid_init_done", init_done, 1'b0);
      end
      @(posedge clk); #1;
      rd_req = 2'b00;
      rst    = 1'b0;
      init_seq();
      for (int k = 0; k < 4; k++) begin
         rd_req[k % 2] = 1'b1;
         if (k % 2 == 0) rd_addr0 = DEPTH'(k); else rd_addr1 = DEPTH'(k);
         step();
      end
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
